// File: rtl/exec.sv
// ---------------------------------------------------------------------------
// exec: execute stage of a simple in-order pipeline.
//
// Selects ALU operands (with forwarding and branch/immediate muxes), performs
// the ALU operation, derives negative/zero flags, and registers the packed
// EX/MEM buffer.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   en              - stage enable (1 = capture, 0 = hold)
//   rd1, rd2        - register operands A and B
//   pc, imm         - program counter, extended immediate
//   aluOut, result  - forwarded values from MEM and WB stages
//   rd3             - store data, passed through
//   aluControl      - ALU operation select
//   Rc              - destination register index, passed through
//   immSrc          - operand B = imm
//   branchFlag      - operand A = pc; passed through
//   memWrite, memToReg, regWrite - control bits, passed through
//   Fa, Fb          - forwarding selects for operands A and B
//   opType, opCode  - instruction class/code, passed through
//   bufferOut       - registered EX/MEM pipeline buffer
// ---------------------------------------------------------------------------
module exec #(
  parameter int N  = 24,
  parameter int BW = 16 + 2 * N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [N-1:0]  rd1,
  input  logic signed [N-1:0]  rd2,
  input  logic signed [N-1:0]  pc,
  input  logic signed [N-1:0]  imm,
  input  logic signed [N-1:0]  aluOut,
  input  logic signed [N-1:0]  result,
  input  logic signed [N-1:0]  rd3,
  input  logic        [3:0]    aluControl,
  input  logic        [3:0]    Rc,
  input  logic                 immSrc,
  input  logic                 branchFlag,
  input  logic                 memWrite,
  input  logic                 memToReg,
  input  logic                 regWrite,
  input  logic                 Fa,
  input  logic                 Fb,
  input  logic        [1:0]    opType,
  input  logic        [3:0]    opCode,
  output logic        [BW-1:0] bufferOut
);

  logic signed [N-1:0]   op_a_s;
  logic signed [N-1:0]   op_b_s;
  logic signed [2*N-1:0] prod_s;
  logic signed [N-1:0]   alu_res_s;
  logic                  neg_flag_s;
  logic                  zero_flag_s;
  logic        [BW-1:0]  buffer_d;
  logic        [BW-1:0]  buffer_q;

  // Operand selection: branch target base beats forwarding for A.
  always_comb begin
    if (branchFlag) begin
      op_a_s = pc;
    end else if (Fa) begin
      op_a_s = aluOut;
    end else begin
      op_a_s = rd1;
    end

    if (immSrc) begin
      op_b_s = imm;
    end else if (Fb) begin
      op_b_s = result;
    end else begin
      op_b_s = rd2;
    end
  end

  // ALU: N-bit two's complement, wraps silently; shift amount uses B[4:0].
  always_comb begin
    prod_s = op_a_s * op_b_s;
    case (aluControl)
      4'd0:    alu_res_s = op_a_s - op_b_s;
      4'd1:    alu_res_s = op_a_s + op_b_s;
      4'd2:    alu_res_s = op_a_s & op_b_s;
      4'd3:    alu_res_s = op_a_s | op_b_s;
      4'd4:    alu_res_s = op_a_s - op_b_s;
      4'd5:    alu_res_s = op_a_s ^ op_b_s;
      4'd6:    alu_res_s = op_a_s << op_b_s[4:0];
      4'd7:    alu_res_s = op_a_s >>> op_b_s[4:0];
      4'd8:    alu_res_s = prod_s[N-1:0];
      default: alu_res_s = {N{1'b0}};
    endcase
    neg_flag_s  = alu_res_s[N-1];
    zero_flag_s = (alu_res_s == {N{1'b0}});
  end

  // Next buffer value: capture packed fields when enabled, otherwise hold.
  always_comb begin
    if (en) begin
      buffer_d = {opType, opCode, alu_res_s, zero_flag_s, neg_flag_s,
                  branchFlag, memWrite, memToReg, regWrite, Rc, rd3};
    end else begin
      buffer_d = buffer_q;
    end
  end

  // EX/MEM buffer register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q <= {BW{1'b0}};
    end else begin
      buffer_q <= buffer_d;
    end
  end

  assign bufferOut = buffer_q;

endmodule

// File: tb/tb_exec.sv
module tb_exec;

  logic               clk = 1'b0;
  logic               rst, en;
  logic signed [23:0] rd1, rd2, pc, imm, aluOut, result, rd3;
  logic        [3:0]  aluControl, Rc, opCode;
  logic               immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb;
  logic        [1:0]  opType;
  logic        [63:0] bufferOut;

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  exec dut (
    .clk(clk), .rst(rst), .en(en), .rd1(rd1), .rd2(rd2), .pc(pc), .imm(imm),
    .aluOut(aluOut), .result(result), .rd3(rd3), .aluControl(aluControl),
    .Rc(Rc), .immSrc(immSrc), .branchFlag(branchFlag), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .Fa(Fa), .Fb(Fb),
    .opType(opType), .opCode(opCode), .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  // Hand-assembled buffer image from individually specified field values.
  function automatic logic [63:0] pk(input logic [1:0] ot, input logic [3:0] oc,
                                     input logic [23:0] alu, input logic z,
                                     input logic n, input logic br,
                                     input logic mw, input logic mtr,
                                     input logic rw, input logic [3:0] rc,
                                     input logic [23:0] d3);
    return {ot, oc, alu, z, n, br, mw, mtr, rw, rc, d3};
  endfunction

  task automatic defaults();
    rst = 1'b0; en = 1'b1;
    rd1 = 24'sd0; rd2 = 24'sd0; pc = 24'sd0; imm = 24'sd0;
    aluOut = 24'sd0; result = 24'sd0; rd3 = 24'sd0;
    aluControl = 4'd0; Rc = 4'd0; opCode = 4'd0; opType = 2'd0;
    immSrc = 1'b0; branchFlag = 1'b0; memWrite = 1'b0; memToReg = 1'b0;
    regWrite = 1'b0; Fa = 1'b0; Fb = 1'b0;
  endtask

  // Queue the expected buffer for the coming edge, then advance to the next negedge.
  task automatic expect_next(input string nm, input logic [63:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Set up a pure ALU vector with control bits cleared.
  task automatic alu_vec(input logic [3:0] ac, input logic [23:0] a,
                         input logic [23:0] b);
    defaults();
    aluControl = ac; rd1 = a; rd2 = b;
  endtask

  // Monitor: compare buffer just after each edge for which something was queued.
  initial begin
    logic [63:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (bufferOut !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, bufferOut, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    defaults();
    rst = 1'b1; en = 1'b0;
    rd1 = 24'sd77; aluControl = 4'd1; rd3 = 24'sd5;
    expect_next("reset_en0", 64'h0);

    // Add 2+2 with Rc=3, opCode=1.
    defaults();
    rd1 = 24'sd2; rd2 = 24'sd2; aluControl = 4'd1; Rc = 4'd3; opCode = 4'd1;
    expect_next("add", 64'h0400_0010_0300_0000);

    // Compare with immediate: 2-2 = 0.
    defaults();
    rd1 = 24'sd2; rd2 = 24'sd9; imm = 24'sd2; immSrc = 1'b1; aluControl = 4'd4;
    expect_next("cmp_imm", pk(2'd0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    // Branch: A=pc=1 (rd1 ignored), B=2 -> -1.
    defaults();
    branchFlag = 1'b1; pc = 24'sd1; rd1 = 24'sd50; Fa = 1'b1; aluOut = 24'sd40;
    rd2 = 24'sd2; aluControl = 4'd0;
    expect_next("branch", pk(2'd0, 4'd0, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    // Forwarding both operands: 10+3.
    defaults();
    Fa = 1'b1; aluOut = 24'sd10; Fb = 1'b1; result = 24'sd3; aluControl = 4'd1;
    expect_next("fwd_on", pk(2'd0, 4'd0, 24'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    defaults();
    aluOut = 24'sd10; result = 24'sd3; aluControl = 4'd1;
    expect_next("fwd_off", pk(2'd0, 4'd0, 24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd1, 24'h7FFFFF, 24'h000001);
    expect_next("wrap", pk(2'd0, 4'd0, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd0, 24'h000005, 24'h000007);
    expect_next("sub_neg", pk(2'd0, 4'd0, 24'hFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd2, 24'hF0F0F0, 24'h3C3C3C);
    expect_next("and", pk(2'd0, 4'd0, 24'h303030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd3, 24'hF0F0F0, 24'h0F0000);
    expect_next("or", pk(2'd0, 4'd0, 24'hFFF0F0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd5, 24'hFFFFFF, 24'h0000FF);
    expect_next("xor", pk(2'd0, 4'd0, 24'hFFFF00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    // Shift amount 0x24 -> low five bits = 4.
    alu_vec(4'd6, 24'h000003, 24'h000024);
    expect_next("sll", pk(2'd0, 4'd0, 24'h000030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd7, 24'h800000, 24'h000004);
    expect_next("sra", pk(2'd0, 4'd0, 24'hF80000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd8, 24'hFFFFFE, 24'h000003);
    expect_next("mul_neg", pk(2'd0, 4'd0, 24'hFFFFFA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd8, 24'h001000, 24'h001000);
    expect_next("mul_trunc", pk(2'd0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd9, 24'h000005, 24'h000003);
    expect_next("op9_zero", pk(2'd0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    alu_vec(4'd15, 24'h123456, 24'h000001);
    expect_next("op15_zero", pk(2'd0, 4'd0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0));

    // Pass-through fields with a nonzero ALU result (3+4=7).
    alu_vec(4'd1, 24'h000003, 24'h000004);
    rd3 = 24'hABCDEF; Rc = 4'hA; regWrite = 1'b1; memToReg = 1'b0;
    memWrite = 1'b1; opCode = 4'hC; opType = 2'd2;
    expect_next("passthru", pk(2'd2, 4'hC, 24'h000007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 24'hABCDEF));

    // Hold: en=0 with changing inputs keeps the pass-through image.
    alu_vec(4'd0, 24'h000009, 24'h000001);
    en = 1'b0; rd3 = 24'h111111; Rc = 4'h5;
    expect_next("hold1", pk(2'd2, 4'hC, 24'h000007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 24'hABCDEF));
    alu_vec(4'd5, 24'h00F00F, 24'h000FF0);
    en = 1'b0; memToReg = 1'b1; opType = 2'd3;
    expect_next("hold2", pk(2'd2, 4'hC, 24'h000007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 24'hABCDEF));

    // Reset with en=1 mid-stream clears everything.
    alu_vec(4'd1, 24'h000020, 24'h000001);
    rst = 1'b1; rd3 = 24'h222222; regWrite = 1'b1;
    expect_next("reset_en1", 64'h0);

    // Resume after reset.
    alu_vec(4'd1, 24'h000020, 24'h000001);
    memToReg = 1'b1; opType = 2'd1;
    expect_next("resume", pk(2'd1, 4'd0, 24'h000021, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 24'h0));

    defaults();
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
